// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the GPIO MMIO port -- register offsets
// (word index, addr[3:2]), default base address and debounce counter width.
package gpio_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

   // Register select values, taken from addr[3:2]
   localparam logic [1:0] OFF_DATA_IN  = 2'd0;
   localparam logic [1:0] OFF_DATA_OUT = 2'd1;
   localparam logic [1:0] OFF_EDGE     = 2'd2;
   localparam logic [1:0] OFF_IE       = 2'd3;

   // Debounce counter width; large enough for a window of up to 255 cycles
   localparam int CNT_W = 8;

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: single-bit stability filter. The output follows the input
// only after the input has disagreed with it for DEB_CYCLES consecutive
// cycles; any reversion restarts the count. 'rise' is a combinational flag
// that is high in the cycle whose clock edge moves the output 0->1.
module gpio_debounce
   import gpio_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             commit;

   // Commit when this is the last disagreeing cycle of the window
   always_comb begin
      commit = (din != dout) && (cnt_q == LAST);
      rise   = commit && din;
   end

   // Count the current run of disagreement; agreement or a commit restarts it
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (rst) begin
         cnt_q <= '0;
         dout  <= 1'b0;
      end else if (din == dout) begin
         cnt_q <= '0;
      end else if (commit) begin
         dout  <= din;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/gpio_mmio_port.sv
// gpio_mmio_port: memory-mapped GPIO block with a 16-byte register window.
//   0x0 DATA_IN  (RO)   filtered inputs, zero-extended
//   0x4 DATA_OUT (RW)   drives GPIO_o
//   0x8 EDGE     (RW1C) rising-edge capture of the filtered inputs
//   0xC IE       (RW)   interrupt enables; irq = registered |(EDGE & IE)
// Every hit is acked exactly one cycle later with the register value that
// was current in the hit cycle. Define GPIO_DEBOUNCE_EN to insert a
// per-bit gpio_debounce filter after the two-flop synchronizer; without it
// the filtered value is the synchronizer output.
module gpio_mmio_port
   import gpio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
   parameter int          IN_W       = 8,
   parameter int          DEB_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic            we,
   input  logic [31:0]     addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic            ack,
   input  logic [IN_W-1:0] GPIO_i,
   output logic [31:0]     GPIO_o,
   output logic            irq
);

   logic [IN_W-1:0] sync1_q;
   logic [IN_W-1:0] sync2_q;
   logic [IN_W-1:0] filt;
   logic [IN_W-1:0] rise;
   logic [31:0]     data_out_q;
   logic [IN_W-1:0] edge_q;
   logic [IN_W-1:0] ie_q;
   logic            hit;
   logic [1:0]      sel;
   logic [31:0]     rd_mux;
   logic [IN_W-1:0] w1c_mask;

   // Byte-lane bits of the address are don't-care for word registers
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^addr[1:0];

   // Two-flop synchronizer for the asynchronous pins
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= GPIO_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   for (genvar i = 0; i < IN_W; i++) begin : g_deb
      gpio_debounce #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
         .clk  (clk),
         .rst  (rst),
         .din  (sync2_q[i]),
         .dout (filt[i]),
         .rise (rise[i])
      );
   end
`else
   localparam int unused_deb_cycles = DEB_CYCLES;

   // Unfiltered: the second synchronizer stage is the filtered value
   always_comb begin
      filt = sync2_q;
      rise = sync1_q & ~sync2_q;
   end
`endif

   // Address decode, read mux and write-one-to-clear mask
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      hit      = req && (addr[31:4] == BASE_ADDR[31:4]);
      sel      = addr[3:2];
      rd_mux   = '0;
      w1c_mask = '0;
      case (sel)
         OFF_DATA_IN:  rd_mux[IN_W-1:0] = filt;
         OFF_DATA_OUT: rd_mux           = data_out_q;
         OFF_EDGE:     rd_mux[IN_W-1:0] = edge_q;
         default:      rd_mux[IN_W-1:0] = ie_q;
      endcase
      if (hit && we && (sel == OFF_EDGE)) begin
         w1c_mask = wdata[IN_W-1:0];
      end
   end

   // Bus response, register writes, edge capture and interrupt
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: all state here is plain flops, so all of it is reset; a
         // RAM-style array would normally be left out of the reset.
         ack        <= 1'b0;
         rdata      <= '0;
         data_out_q <= '0;
         edge_q     <= '0;
         ie_q       <= '0;
         irq        <= 1'b0;
      end else begin
         ack   <= hit;
         rdata <= hit ? rd_mux : '0;
         if (hit && we) begin
            case (sel)
               OFF_DATA_OUT: data_out_q <= wdata;
               OFF_IE:       ie_q       <= wdata[IN_W-1:0];
               default:      ;
            endcase
         end
         // A new rising edge wins over a same-cycle clear of that bit
         edge_q <= (edge_q & ~w1c_mask) | rise;
         irq    <= |(edge_q & ie_q);
      end
   end

   assign GPIO_o = data_out_q;

endmodule

// File: tb/tb_gpio_mmio_port.sv
// tb_gpio_mmio_port: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the register block. The input
// filter is modelled as a window over the history of sampled pin values.
`timescale 1ns/1ps
module tb_gpio_mmio_port;
   import gpio_pkg::*;

   localparam logic [31:0] BASE = 32'h1001_0000;
   localparam int IN_W = 8;
   localparam int DEB  = 4;
`ifdef GPIO_DEBOUNCE_EN
   localparam int LAT = 2 + DEB;
   localparam logic [31:0] GLITCH_EDGE = 32'h0;
`else
   localparam int LAT = 2;
   localparam logic [31:0] GLITCH_EDGE = 32'h1;
`endif
   localparam int HIST = DEB + 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            req;
   logic            we;
   logic [31:0]     addr;
   logic [31:0]     wdata;
   logic [31:0]     rdata;
   logic            ack;
   logic [IN_W-1:0] gpio_in;
   logic [31:0]     gpio_o;
   logic            irq;

   gpio_mmio_port #(
      .BASE_ADDR  (BASE),
      .IN_W       (IN_W),
      .DEB_CYCLES (DEB)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .we     (we),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .ack    (ack),
      .GPIO_i (gpio_in),
      .GPIO_o (gpio_o),
      .irq    (irq)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state; samp[j] is the pin value sampled j edges ago
   logic [IN_W-1:0] samp [HIST];
   logic [31:0]     m_out;
   logic [31:0]     m_rdata;
   logic [IN_W-1:0] m_filt;
   logic [IN_W-1:0] m_edge;
   logic [IN_W-1:0] m_ie;
   logic            m_ack;
   logic            m_irq;

   function automatic logic [31:0] ra(input logic [1:0] off);
      return BASE | {28'h0, off, 2'b00};
   endfunction

   // Advance one clock edge and update the model with the pre-edge inputs
   task automatic tick();
      logic            hit;
      logic [1:0]      sel;
      logic [31:0]     rd;
      logic [IN_W-1:0] ns [HIST];
      logic [IN_W-1:0] nfilt, nedge, nie, w1c;
      logic [31:0]     nout, nrdata;
      logic            nack, nirq;
      hit = req && (addr[31:4] == BASE[31:4]);
      sel = addr[3:2];
      if (rst) begin
         for (int i = 0; i < HIST; i++) ns[i] = '0;
         nfilt = '0; nedge = '0; nie = '0; nout = '0;
         nrdata = '0; nack = 1'b0; nirq = 1'b0;
      end else begin
         ns[0] = gpio_in;
         for (int i = 1; i < HIST; i++) ns[i] = samp[i-1];
`ifdef GPIO_DEBOUNCE_EN
         // A bit takes value v once the last DEB synchronized values were all v
         nfilt = m_filt;
         for (int b = 0; b < IN_W; b++) begin
            logic stable;
            stable = 1'b1;
            for (int j = 2; j < DEB + 2; j++) if (ns[j][b] != ns[2][b]) stable = 1'b0;
            if (stable) nfilt[b] = ns[2][b];
         end
`else
         nfilt = ns[1];
`endif
         rd = '0;
         case (sel)
            2'd0:    rd[IN_W-1:0] = m_filt;
            2'd1:    rd = m_out;
            2'd2:    rd[IN_W-1:0] = m_edge;
            default: rd[IN_W-1:0] = m_ie;
         endcase
         nack   = hit;
         nrdata = hit ? rd : 32'h0;
         nout = m_out; nie = m_ie; w1c = '0;
         if (hit && we) begin
            case (sel)
               2'd1:    nout = wdata;
               2'd2:    w1c  = wdata[IN_W-1:0];
               2'd3:    nie  = wdata[IN_W-1:0];
               default: ;
            endcase
         end
         nedge = (m_edge & ~w1c) | (nfilt & ~m_filt);
         nirq  = |(m_edge & m_ie);
      end
      @(posedge clk);
      #1;
      samp = ns;
      m_filt = nfilt; m_edge = nedge; m_ie = nie; m_out = nout;
      m_rdata = nrdata; m_ack = nack; m_irq = nirq;
   endtask

   task automatic idle(input int n);
      req = 1'b0; we = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
      req = 1'b1; we = w; addr = a; wdata = d;
      tick();
      req = 1'b0; we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; gpio_in = 8'hFF;
      req = 1'b1; we = 1'b1; addr = ra(OFF_DATA_OUT); wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_tests++; if (gpio_o !== 32'h0) begin n_fail++; $display("FAIL reset_gpio_o: got %h want 00000000", gpio_o); end
         n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
         n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
         n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
      end
      rst = 1'b0; req = 1'b0; we = 1'b0;
      tick();
      n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_hit_discarded_ack: got %b want 0", ack); end
      n_tests++; if (gpio_o !== 32'h0) begin n_fail++; $display("FAIL reset_hit_discarded_gpio_o: got %h want 00000000", gpio_o); end
   endtask

   task automatic test_data_out();
      bus(1'b1, ra(OFF_DATA_OUT), 32'hDEAD_BEEF);
      n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL dout_write_ack: got %b want 1", ack); end
      n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL dout_write_prewrite_rdata: got %h want 00000000", rdata); end
      n_tests++; if (gpio_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dout_gpio_o: got %h want deadbeef", gpio_o); end
      bus(1'b0, ra(OFF_DATA_OUT), 32'h0);
      n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL dout_read_ack: got %b want 1", ack); end
      n_tests++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dout_read_rdata: got %h want deadbeef", rdata); end
      idle(1);
      n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL dout_idle_ack: got %b want 0", ack); end
      n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL dout_idle_rdata: got %h want 00000000", rdata); end
   endtask

   task automatic test_reg_widths();
      idle(LAT + 2);
      bus(1'b1, ra(OFF_DATA_IN), 32'h0);
      n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL din_write_ack: got %b want 1", ack); end
      bus(1'b0, ra(OFF_DATA_IN), 32'h0);
      n_tests++; if (rdata !== 32'h0000_00FF) begin n_fail++; $display("FAIL din_read: got %h want 000000ff", rdata); end
      bus(1'b1, ra(OFF_IE), 32'hFFFF_FFFF);
      bus(1'b0, ra(OFF_IE), 32'h0);
      n_tests++; if (rdata !== 32'h0000_00FF) begin n_fail++; $display("FAIL ie_upper_bits: got %h want 000000ff", rdata); end
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ie_all_irq: got %b want 1", irq); end
      bus(1'b0, ra(OFF_EDGE), 32'h0);
      n_tests++; if (rdata !== 32'h0000_00FF) begin n_fail++; $display("FAIL edge_after_reset_rise: got %h want 000000ff", rdata); end
      bus(1'b1, ra(OFF_EDGE), 32'hFFFF_FFFF);
      bus(1'b0, ra(OFF_EDGE), 32'h0);
      n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL edge_w1c_all: got %h want 00000000", rdata); end
      bus(1'b1, ra(OFF_IE), 32'h0);
   endtask

   task automatic test_edge_irq();
      gpio_in = 8'h00;
      idle(LAT + 2);
      bus(1'b1, ra(OFF_EDGE), 32'hFF);
      bus(1'b1, ra(OFF_IE), 32'h01);
      idle(1);
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_irq_quiet: got %b want 0", irq); end
      gpio_in = 8'h03;
      idle(LAT - 1);
      bus(1'b0, ra(OFF_EDGE), 32'h0);
      n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL edge_before_latency: got %h want 00000000", rdata); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_before_latency: got %b want 0", irq); end
      bus(1'b0, ra(OFF_EDGE), 32'h0);
      n_tests++; if (rdata !== 32'h3) begin n_fail++; $display("FAIL edge_at_latency: got %h want 00000003", rdata); end
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_edge: got %b want 1", irq); end
      bus(1'b0, ra(OFF_DATA_IN), 32'h0);
      n_tests++; if (rdata !== 32'h3) begin n_fail++; $display("FAIL din_after_edge: got %h want 00000003", rdata); end
   endtask

   task automatic test_glitch();
      gpio_in = 8'h00;
      idle(LAT + 2);
      bus(1'b1, ra(OFF_EDGE), 32'hFF);
      gpio_in = 8'h01;
      idle(2);
      gpio_in = 8'h00;
      idle(LAT + 3);
      bus(1'b0, ra(OFF_EDGE), 32'h0);
      n_tests++; if (rdata !== GLITCH_EDGE) begin n_fail++; $display("FAIL glitch_edge: got %h want %h", rdata, GLITCH_EDGE); end
      bus(1'b0, ra(OFF_DATA_IN), 32'h0);
      n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL glitch_din: got %h want 00000000", rdata); end
      bus(1'b1, ra(OFF_EDGE), 32'hFF);
   endtask

   task automatic test_w1c_race();
      gpio_in = 8'h01;
      idle(LAT - 1);
      bus(1'b1, ra(OFF_EDGE), 32'h1);
      n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL race_write_ack: got %b want 1", ack); end
      bus(1'b0, ra(OFF_EDGE), 32'h0);
      n_tests++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL race_set_wins: got %h want 00000001", rdata); end
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL race_irq: got %b want 1", irq); end
      bus(1'b1, ra(OFF_EDGE), 32'h1);
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_same_cycle: got %b want 1", irq); end
      idle(1);
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_drop: got %b want 0", irq); end
      bus(1'b0, ra(OFF_EDGE), 32'h0);
      n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL w1c_cleared: got %h want 00000000", rdata); end
   endtask

   task automatic test_reset_mid_debounce();
      gpio_in = 8'h00;
      idle(LAT + 2);
      bus(1'b1, ra(OFF_EDGE), 32'hFF);
      gpio_in = 8'h02;
      idle(LAT - 1);
      rst = 1'b1; gpio_in = 8'h00;
      tick();
      rst = 1'b0;
      idle(LAT + 3);
      bus(1'b0, ra(OFF_EDGE), 32'h0);
      n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_edge: got %h want 00000000", rdata); end
      bus(1'b0, ra(OFF_DATA_IN), 32'h0);
      n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_din: got %h want 00000000", rdata); end
      n_tests++; if (gpio_o !== 32'h0) begin n_fail++; $display("FAIL midreset_gpio_o: got %h want 00000000", gpio_o); end
   endtask

   task automatic test_back_to_back();
      logic        b2b_we   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0]  b2b_off  [4] = '{OFF_IE, OFF_IE, OFF_DATA_OUT, OFF_DATA_OUT};
      logic [31:0] b2b_wd   [4] = '{32'h5A, 32'h0, 32'hA5A5, 32'h0};
      logic [31:0] b2b_exp  [4] = '{32'h0, 32'h5A, 32'h1234_5678, 32'hA5A5};
      bus(1'b1, ra(OFF_DATA_OUT), 32'h1234_5678);
      bus(1'b1, 32'h1002_0004, 32'hFFFF_FFFF);
      n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL miss_ack_other_block: got %b want 0", ack); end
      n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL miss_rdata: got %h want 00000000", rdata); end
      bus(1'b1, BASE + 32'h14, 32'hFFFF_FFFF);
      n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL miss_ack_past_window: got %b want 0", ack); end
      bus(1'b0, 32'h1002_0000, 32'h0);
      n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL miss_ack_read: got %b want 0", ack); end
      bus(1'b0, ra(OFF_DATA_OUT), 32'h0);
      n_tests++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL miss_no_change: got %h want 12345678", rdata); end
      for (int i = 0; i < 4; i++) begin
         req = 1'b1; we = b2b_we[i]; addr = ra(b2b_off[i]); wdata = b2b_wd[i];
         tick();
         n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack[%0d]: got %b want 1", i, ack); end
         n_tests++; if (rdata !== b2b_exp[i]) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rdata, b2b_exp[i]); end
      end
      req = 1'b0; we = 1'b0;
      n_tests++; if (gpio_o !== 32'hA5A5) begin n_fail++; $display("FAIL b2b_gpio_o: got %h want 0000a5a5", gpio_o); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         int b;
         rst = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 5) == 0) begin
            b = $urandom_range(0, IN_W - 1);
            gpio_in[b] = ~gpio_in[b];
         end
         req   = ($urandom_range(0, 2) != 0);
         we    = 1'($urandom_range(0, 1));
         addr  = ($urandom_range(0, 4) == 0) ? $urandom : (BASE | ($urandom & 32'hF));
         wdata = $urandom;
         tick();
         n_tests++; if (ack !== m_ack) begin n_fail++; $display("FAIL rand_ack cycle %0d: got %b want %b", c, ack, m_ack); end
         n_tests++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata cycle %0d: got %h want %h", c, rdata, m_rdata); end
         n_tests++; if (gpio_o !== m_out) begin n_fail++; $display("FAIL rand_gpio_o cycle %0d: got %h want %h", c, gpio_o, m_out); end
         n_tests++; if (irq !== m_irq) begin n_fail++; $display("FAIL rand_irq cycle %0d: got %b want %b", c, irq, m_irq); end
      end
      rst = 1'b0; req = 1'b0; we = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; gpio_in = '0;
      test_reset();
      test_data_out();
      test_reg_widths();
      test_edge_irq();
      test_glitch();
      test_w1c_race();
      test_reset_mid_debounce();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
